// File: rtl/mem_line_arbiter_pkg.sv
// mem_arb_pkg: shared state/op encodings and channel-index sizing for mem_line_arbiter
package mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_e;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_line_arbiter_if.sv
// mem_line_arbiter_if: requester-side and memory-side handshake bundle of the line arbiter
interface mem_line_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [NUM_CH-1:0]             ch_read;
  logic [NUM_CH-1:0]             ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_address;
  logic [NUM_CH-1:0][LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]             ch_resp;
  logic [LINE_W-1:0]             ch_rdata;
  logic                          mem_read;
  logic                          mem_write;
  logic [ADDR_W-1:0]             mem_address;
  logic [LINE_W-1:0]             mem_wdata;
  logic [LINE_W-1:0]             mem_rdata;
  logic                          mem_resp;
  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, mem_rdata, mem_resp,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata
  );
  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, mem_rdata, mem_resp,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_line_arbiter_rr_picker.sv
// rr_picker: stateless round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              any_req
);
  logic [NUM_CH-1:0] hi;
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = i >= int'(ptr);
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) grant = IDX_W'(i);
    // a request at or above ptr overrides the wrapped-around fallback
    for (int i = NUM_CH - 1; i >= 0; i--) if (req[i] & hi[i]) grant = IDX_W'(i);
    any_req = |req;
  end
endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: round-robin N-channel cache-line arbiter onto one memory port (optional MEM_ARB_TIMEOUT_EN)
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  mem_line_arbiter_if.slave  bus,
  output logic               proto_err,
  output logic               timeout_err
);
  localparam int IDX_W = ch_idx_w(NUM_CH);
  arb_state_e        state, nxt;
  arb_op_e           op;
  logic [IDX_W-1:0]  rr_ptr, grant, pick;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              any_req, busy, resp_fire, to_hit, take;
  rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req    (bus.ch_read | bus.ch_write),
    .ptr    (rr_ptr),
    .grant  (pick),
    .any_req(any_req)
  );
  always_comb begin
    busy            = state == BUSY;
    resp_fire       = busy && bus.mem_resp;
    take            = (state == IDLE) && any_req;
    nxt             = busy ? ((resp_fire || to_hit) ? IDLE : BUSY) : (any_req ? BUSY : IDLE);
    bus.mem_read    = busy && op == OP_READ;
    bus.mem_write   = busy && op == OP_WRITE;
    bus.mem_address = busy ? addr_q : '0;
    bus.mem_wdata   = busy ? wdata_q : '0;
    bus.ch_rdata    = resp_fire ? bus.mem_rdata : '0;
    bus.ch_resp     = resp_fire ? (NUM_CH'(1) << grant) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      op        <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        grant   <= pick;
        op      <= bus.ch_write[pick] ? OP_WRITE : OP_READ;
        addr_q  <= bus.ch_address[pick];
        wdata_q <= bus.ch_wdata[pick];
        if (bus.ch_read[pick] && bus.ch_write[pick]) proto_err <= 1'b1;
      end
      // aborted transactions advance the pointer too, so a dead channel cannot starve others
      if (resp_fire || to_hit) rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to_hit = busy && !bus.mem_resp && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= busy ? cnt + 1'b1 : '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: cycle-by-cycle vector table plus a timeout sequence for mem_line_arbiter
module tb_mem_line_arbiter;
  logic clk = 1'b0, rst = 1'b1, proto_err, timeout_err;
  int total = 0, bad = 0;
  localparam logic [255:0] W0 = {8{32'h0123_4567}};
  localparam logic [255:0] W1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] RD = {32{8'hA5}};
  mem_line_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256)) bus ();
  mem_line_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .proto_err(proto_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst; logic [1:0] rd, wr; logic [31:0] a0, a1; logic resp;
    logic mrd, mwr; logic [31:0] maddr; int wsel; logic [1:0] cresp; logic perr;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input logic r, input logic [1:0] rd, wr, input logic [31:0] a0, a1,
                             input logic resp, mrd, mwr, input logic [31:0] maddr, input int wsel,
                             input logic [1:0] cresp, input logic perr);
    vec_t x;
    x.rst = r; x.rd = rd; x.wr = wr; x.a0 = a0; x.a1 = a1; x.resp = resp;
    x.mrd = mrd; x.mwr = mwr; x.maddr = maddr; x.wsel = wsel; x.cresp = cresp; x.perr = perr;
    return x;
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [1:0] rd, wr, input logic [31:0] a0, a1, input logic resp);
    rst = r; bus.ch_read = rd; bus.ch_write = wr;
    bus.ch_address[0] = a0; bus.ch_address[1] = a1; bus.mem_resp = resp;
  endtask
  initial begin
    bus.ch_wdata[0] = W0;
    bus.ch_wdata[1] = W1;
    bus.mem_rdata   = RD;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    // single read on ch0, memory answers in the third busy cycle; stray resp in idle
    tbl.push_back(v(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 1, 0, 'h60,  0, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 1, 0, 'h60,  0, 0, 1, 0, 'h60,  2, 0, 0));
    tbl.push_back(v(0, 1, 0, 'h60,  0, 0, 1, 0, 'h60,  2, 0, 0));
    tbl.push_back(v(0, 1, 0, 'h60,  0, 1, 1, 0, 'h60,  2, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 1, 0, 0, 0,     0, 0, 0));
    // round robin 0,1,0,1 from reset
    tbl.push_back(v(1, 0, 0, 0,     0,     0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 1, 1, 0, 'h200, 2, 1, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 1, 1, 0, 'h300, 1, 2, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 1, 1, 0, 'h200, 2, 1, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h200, 'h300, 1, 1, 0, 'h300, 1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0,     0,     0, 0, 0, 0,     0, 0, 0));
    // ch1 write held stable while ch0 address toggles
    tbl.push_back(v(0, 0, 2, 'h40,  'h100, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 0, 2, 'h80,  'h100, 0, 0, 1, 'h100, 1, 0, 0));
    tbl.push_back(v(0, 0, 2, 'h40,  'h100, 0, 0, 1, 'h100, 1, 0, 0));
    tbl.push_back(v(0, 0, 2, 'h80,  'h100, 1, 0, 1, 'h100, 1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0,     0,     0, 0, 0, 0,     0, 0, 0));
    // read+write together on ch0
    tbl.push_back(v(0, 1, 1, 'h20,  0, 0, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 1, 1, 'h20,  0, 0, 0, 1, 'h20,  2, 0, 1));
    tbl.push_back(v(0, 1, 1, 'h20,  0, 1, 0, 1, 'h20,  2, 1, 1));
    tbl.push_back(v(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 1));
    // reset two cycles into a ch1 grant, then ch0 wins
    tbl.push_back(v(0, 3, 0, 'h20,  'h300, 0, 0, 0, 0,     0, 0, 1));
    tbl.push_back(v(0, 3, 0, 'h20,  'h300, 0, 1, 0, 'h300, 1, 0, 1));
    tbl.push_back(v(1, 3, 0, 'h20,  'h300, 0, 1, 0, 'h300, 1, 0, 1));
    tbl.push_back(v(0, 3, 0, 'h20,  'h300, 1, 0, 0, 0,     0, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h20,  'h300, 0, 1, 0, 'h20,  2, 0, 0));
    tbl.push_back(v(0, 3, 0, 'h20,  'h300, 1, 1, 0, 'h20,  2, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0,     0, 0, 0, 0,     0, 0, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].resp);
      #1;
      chk($sformatf("r%0d mem_read", i),    256'(bus.mem_read),    256'(tbl[i].mrd));
      chk($sformatf("r%0d mem_write", i),   256'(bus.mem_write),   256'(tbl[i].mwr));
      chk($sformatf("r%0d mem_address", i), 256'(bus.mem_address), 256'(tbl[i].maddr));
      chk($sformatf("r%0d mem_wdata", i),   bus.mem_wdata,
          tbl[i].wsel == 1 ? W1 : tbl[i].wsel == 2 ? W0 : 256'(0));
      chk($sformatf("r%0d ch_resp", i),     256'(bus.ch_resp),     256'(tbl[i].cresp));
      chk($sformatf("r%0d ch_rdata", i),    bus.ch_rdata,          tbl[i].cresp != 0 ? RD : 256'(0));
      chk($sformatf("r%0d proto_err", i),   256'(proto_err),       256'(tbl[i].perr));
      chk($sformatf("r%0d timeout_err", i), 256'(timeout_err),     256'(0));
    end
`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 3, 0, 'h20, 'h300, 0);
    #1 chk("to idle mem_read", 256'(bus.mem_read), 256'(0));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to busy%0d mem_read", k), 256'(bus.mem_read), 256'(1));
      chk($sformatf("to busy%0d timeout_err", k), 256'(timeout_err), 256'(0));
    end
    @(negedge clk);
    #1;
    chk("to abort mem_read", 256'(bus.mem_read), 256'(0));
    chk("to abort ch_resp", 256'(bus.ch_resp), 256'(0));
    chk("to abort timeout_err", 256'(timeout_err), 256'(1));
    @(negedge clk);
    #1;
    chk("to next mem_read", 256'(bus.mem_read), 256'(1));
    chk("to next mem_address", 256'(bus.mem_address), 256'(32'h300));
    chk("to next timeout_err", 256'(timeout_err), 256'(1));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
